// File: rtl/prior_scan_encoder.sv
// Drains a request vector: emits the index of every set bit, highest priority first, one per beat.
// Latency: vector accepted at edge N gives its first beat in cycle N+1; one index per cycle after that.
// Backpressure: out_idx/out_last/pend hold while out_ready is low; a new vector is taken on the final beat.
module prior_scan_encoder #(
    parameter int WIDTH     = 8,
    parameter int IDXW      = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             zero_det
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pend, pend_nxt;
    logic             zero_nxt;
    logic             beat;
    logic             accept;

    // Later matches overwrite earlier ones, so the loop direction sets the priority.
    always_comb begin
        out_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++)
                if (pend[i]) out_idx = IDXW'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (pend[i]) out_idx = IDXW'(i);
        end
    end

    assign out_last  = (pend != '0) && ((pend & (pend - ONE)) == '0);
    assign out_valid = (state == SCAN);
    assign beat      = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (beat && out_last);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        zero_nxt  = 1'b0;
        if (beat) begin
            pend_nxt = pend & ~(ONE << out_idx);
            if (out_last) state_nxt = IDLE;
        end
        // A load on the final beat overrides the clear, giving back-to-back vectors.
        if (accept) begin
            if (in_data != '0) begin
                pend_nxt  = in_data;
                state_nxt = SCAN;
            end else begin
                zero_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend     <= '0;
            zero_det <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            zero_det <= zero_nxt;
        end
    end

endmodule

// File: tb/tb_prior_scan_encoder.sv
// Directed-vector bench for prior_scan_encoder: 8-bit MSB-first and 12-bit LSB-first instances.
module tb_prior_scan_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_last, zero_det;
    logic [7:0] in_data;
    logic [2:0] out_idx;

    logic        v12, r12, ir12, ov12, ol12, zd12;
    logic [11:0] d12;
    logic [3:0]  oi12;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prior_scan_encoder #(.WIDTH(8), .IDXW(3), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .zero_det(zero_det)
    );

    prior_scan_encoder #(.WIDTH(12), .IDXW(4), .MSB_FIRST(1'b0)) u_dut12 (
        .clk(clk), .rst(rst),
        .in_valid(v12), .in_ready(ir12), .in_data(d12),
        .out_valid(ov12), .out_ready(r12), .out_idx(oi12),
        .out_last(ol12), .zero_det(zd12)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are then changed at +1 and outputs checked at +2.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat8(input string tag, input int idx, input bit last);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
        chk({tag, "_last"}, 32'(out_last), 32'(last));
    endtask

    task automatic beat12(input string tag, input int idx, input bit last);
        chk({tag, "_vld"}, 32'(ov12), 32'd1);
        chk({tag, "_idx"}, 32'(oi12), 32'(idx));
        chk({tag, "_last"}, 32'(ol12), 32'(last));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        v12 = 1'b0; d12 = '0; r12 = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_rdy", 32'(in_ready), 1);
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_zero", 32'(zero_det), 0);

        // 1: A1 with free-flowing output -> 7, 5, 0(last)
        in_valid = 1'b1; in_data = 8'hA1; #1;
        chk("t1_accept_rdy", 32'(in_ready), 1);
        step(); in_valid = 1'b0; in_data = 8'hFF; #1;
        beat8("t1_b0", 7, 0);
        chk("t1_b0_rdy", 32'(in_ready), 0);
        step(); #1; beat8("t1_b1", 5, 0);
        step(); #1; beat8("t1_b2", 0, 1);
        chk("t1_b2_rdy", 32'(in_ready), 1);
        step(); #1;
        chk("t1_idle_vld", 32'(out_valid), 0);

        // 2: same vector, stall 3 cycles on the second beat
        in_valid = 1'b1; in_data = 8'hA1; #1;
        step(); in_valid = 1'b0; #1;
        beat8("t2_b0", 7, 0);
        step(); out_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            beat8($sformatf("t2_hold%0d", i), 5, 0);
            chk($sformatf("t2_hold%0d_rdy", i), 32'(in_ready), 0);
            step(); #1;
        end
        out_ready = 1'b1; #1;
        beat8("t2_b1", 5, 0);
        step(); #1; beat8("t2_b2", 0, 1);
        step(); #1;
        chk("t2_idle_vld", 32'(out_valid), 0);

        // 3: all-zero vector -> single zero_det pulse
        in_valid = 1'b1; in_data = 8'h00; #1;
        chk("t3_rdy", 32'(in_ready), 1);
        step(); in_valid = 1'b0; #1;
        chk("t3_zd", 32'(zero_det), 1);
        chk("t3_vld", 32'(out_valid), 0);
        chk("t3_rdy2", 32'(in_ready), 1);
        step(); #1;
        chk("t3_zd_off", 32'(zero_det), 0);
        chk("t3_vld2", 32'(out_valid), 0);

        // 4: 81 then 10 offered on the final beat -> 7, 0(last), 4(last)
        in_valid = 1'b1; in_data = 8'h81; #1;
        step(); in_valid = 1'b0; #1;
        beat8("t4_b0", 7, 0);
        step(); in_valid = 1'b1; in_data = 8'h10; #1;
        beat8("t4_b1", 0, 1);
        chk("t4_b2b_rdy", 32'(in_ready), 1);
        step(); in_valid = 1'b0; #1;
        beat8("t4_b2", 4, 1);
        step(); #1;
        chk("t4_idle_vld", 32'(out_valid), 0);

        // 5: 12-bit LSB-first, 901 -> 0, 8, 11(last)
        v12 = 1'b1; d12 = 12'h901; #1;
        chk("t5_rdy", 32'(ir12), 1);
        step(); v12 = 1'b0; #1;
        beat12("t5_b0", 0, 0);
        step(); #1; beat12("t5_b1", 8, 0);
        step(); #1; beat12("t5_b2", 11, 1);
        step(); #1;
        chk("t5_idle_vld", 32'(ov12), 0);

        // 6: reset mid-scan of FF, then 02 -> 1(last)
        in_valid = 1'b1; in_data = 8'hFF; #1;
        step(); in_valid = 1'b0; #1;
        beat8("t6_b0", 7, 0);
        step(); rst = 1'b1; #1;
        beat8("t6_b1", 6, 0);
        step(); rst = 1'b0; #1;
        chk("t6_rst_vld", 32'(out_valid), 0);
        chk("t6_rst_rdy", 32'(in_ready), 1);
        chk("t6_rst_idx", 32'(out_idx), 0);
        in_valid = 1'b1; in_data = 8'h02; #1;
        step(); in_valid = 1'b0; #1;
        beat8("t6_new", 1, 1);
        step(); #1;
        chk("t6_idle_vld", 32'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
